dma_controller: RTL
===================

// Module: dma_controller
// PURPOSE
//  Memory-to-memory byte DMA engine for the 65C02 SoC. It sits in one mmio_controller slot, as a register file
//  for the CPU, and becomes a second master on the RAM/MMIO bus. It stalls the CPU via RDY while it owns the bus.
//  It copies LEN bytes from SRC to DST in bursts and releases the bus between bursts so the CPU keeps running.
//  On completion it sets sticky DONE and can raise IRQ.
// PARAMETERS
//  ADDR_W       16  bus address width
//  BURST_LEN    16  bytes moved per bus tenure (>=1)
//  YIELD_CYCLES 4   cycles bus_req held low between bursts (>=1)
// PORTS
//  clk        in   1       system clock; single clock domain
//  rst        in   1       synchronous, active-high reset
//  cs         in   1       slot select from mmio_controller
//  we         in   1       slot write enable (active high)
//  rs         in   4       register select
//  din        in   8       slot write data
//  dout       out  8       slot read data, registered, valid 1 cycle after cs
//  bus_req    out  1       DMA wants the bus; top drives CPU RDY = ~bus_req
//  bus_gnt    in   1       top: CPU halted, DMA owns bus; must stay high while bus_req high
//  mem_addr   out  ADDR_W  DMA bus address, valid in RD/WR states
//  mem_we     out  1       DMA write strobe (WR state only)
//  mem_wdata  out  8       DMA write data
//  mem_rdata  in   8       bus read data, 1-cycle synchronous latency (RAM dob / mmio_rd_data)
//  irq        out  1       level: DONE & IRQ_EN
// BEHAVIOUR
//  Registers (rs): 0 SRC_LO, 1 SRC_HI, 2 DST_LO, 3 DST_HI, 4 LEN_LO, 5 LEN_HI, 6 CTRL, 7 STATUS. rs 8-15 read 0.
//  CTRL bits: [0] START (write-1 pulse, reads 0), [1] IRQ_EN, [2] DST_FIXED (DST not incremented; MMIO port target),
//   [3] ABORT (write-1 pulse, reads 0).
//  STATUS bits: [0] BUSY, [1] DONE (sticky; write 1 to clear), [2] ABORTED (sticky; write 1 to clear).
//  SRC/DST/LEN are live counters; reads return current values. Writes to 0-5 while BUSY are ignored.
//  Reset: all registers 0, state IDLE, dout=0, bus_req=0, mem_we=0, mem_addr=0, mem_wdata=0, irq=0.
//  FSM states IDLE, REQ, RD, WR, YIELD:
//   IDLE : START with LEN!=0 -> REQ, BUSY=1, burst_cnt=0.
//          START with LEN==0 -> DONE=1 next cycle; no bus activity.
//   REQ  : bus_req=1; when bus_gnt=1 -> RD.
//   RD   : mem_addr=SRC, mem_we=0; -> WR.
//   WR   : mem_addr=DST, mem_we=1, mem_wdata=mem_rdata.
//          Updates: SRC+=1; DST+=1 unless DST_FIXED; LEN-=1; burst_cnt+=1. All counters wrap mod 2^16.
//          Exit priority:
//           LEN becomes 0             -> IDLE, BUSY=0, DONE=1, bus_req=0.
//           abort latched             -> IDLE, BUSY=0, ABORTED=1.
//           burst_cnt==BURST_LEN      -> YIELD, bus_req=0.
//           otherwise                 -> RD.
//   YIELD: bus_req=0 for YIELD_CYCLES cycles -> REQ, burst_cnt=0. ABORT here -> IDLE immediately, ABORTED=1.
//  Throughput: 2 cycles/byte inside a burst. bus_req stays high from REQ through the last WR of the burst.
//  ABORT during REQ/RD/WR is latched. The byte in flight always completes; no partial write.
//  ABORT when idle has no effect.
//  START while BUSY is ignored.
//  START and DONE-clear in the same write cycle: the write is valid only via separate regs (6 vs 7), so this
//   cannot happen in one cycle.
//  Slot write and FSM update of the same counter in one cycle: FSM wins (the write is already ignored while BUSY).
//  DONE set and a DONE write-1-clear in the same cycle: set wins.
//  rst mid-transfer: immediate return to reset state; bus_req drops the same edge; no further mem_we.
//  bus_gnt falling while bus_req=1 is a top-level protocol error (bench assertion); DMA behaviour undefined.
// STRUCTURE
//  Shared include dma_defs.vh:
//   register offsets (DMA_SRC_LO..DMA_STATUS)
//   CTRL/STATUS bit indices
//   FSM state localparams (3-bit encoding)
//  Sub-module dma_regs: slot decode, register file, registered dout, DONE/ABORTED sticky logic.
//  dma_controller: FSM, counters, bus outputs. top ties dma into mmio slot #1 ($6100) and muxes AD/WE/DO with CPU by bus_gnt.
// TESTING
//  1. Reset then read all 8 regs -> all 0x00. irq=0, bus_req=0.
//  2. SRC=0x0200, DST=0x0300, LEN=4, START
//     -> 8 DMA cycles after grant; RAM[0x300..0x303] == RAM[0x200..0x203].
//     -> STATUS=0x02; SRC=0x0204, LEN=0.
//  3. LEN=40, BURST_LEN=16 -> bus_req high for exactly 3 tenures (16, 16, 8 bytes).
//     -> each gap is YIELD_CYCLES=4 cycles low; CPU executes instructions in the gaps.
//  4. DST=0x6000, DST_FIXED=1, LEN=3 from 0x0400 -> three writes all at 0x6000 (VIA ORB), in source order.
//  5. LEN=100, ABORT after 10th WR -> exactly 11 bytes written; STATUS=0x04, bus_req=0 next cycle.
//  6. LEN=0 START -> DONE=1 next cycle, no bus_req. With IRQ_EN=1 irq=1. Write STATUS=0x02 -> irq=0.
//     Mid-transfer rst -> all outputs 0 next cycle.

Source files
------------

// File: rtl/dma_controller_pkg.sv
// rtl/dma_controller_pkg.sv - shared register map, bit indices and FSM encoding for the byte DMA engine
package dma_controller_pkg;

  localparam logic [3:0] REG_SRC_LO = 4'd0;
  localparam logic [3:0] REG_SRC_HI = 4'd1;
  localparam logic [3:0] REG_DST_LO = 4'd2;
  localparam logic [3:0] REG_DST_HI = 4'd3;
  localparam logic [3:0] REG_LEN_LO = 4'd4;
  localparam logic [3:0] REG_LEN_HI = 4'd5;
  localparam logic [3:0] REG_CTRL   = 4'd6;
  localparam logic [3:0] REG_STATUS = 4'd7;

  localparam int CTRL_START     = 0;
  localparam int CTRL_IRQ_EN    = 1;
  localparam int CTRL_DST_FIXED = 2;
  localparam int CTRL_ABORT     = 3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_RD    = 3'd2,
    ST_WR    = 3'd3,
    ST_YIELD = 3'd4
  } dma_state_t;

endpackage

// File: rtl/dma_controller_regs.sv
// rtl/dma_controller_regs.sv - slot decode, control bits, sticky status and registered read port
module dma_controller_regs
  import dma_controller_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cs,
  input  logic        i_we,
  input  logic [3:0]  i_rs,
  input  logic [7:0]  i_din,
  input  logic        i_busy,
  input  logic [15:0] i_src,
  input  logic [15:0] i_dst,
  input  logic [15:0] i_len,
  input  logic        i_set_done,
  input  logic        i_set_aborted,
  output logic [7:0]  o_dout,
  output logic [5:0]  o_cnt_wr,
  output logic        o_start,
  output logic        o_abort,
  output logic        o_irq_en,
  output logic        o_dst_fixed,
  output logic        o_irq
);

  logic       w_wr;
  logic       w_ctrl_wr;
  logic       w_stat_wr;
  logic [7:0] w_rd_data;
  logic [7:0] r_dout;
  logic       r_irq_en;
  logic       r_dst_fixed;
  logic       r_done;
  logic       r_aborted;

  assign w_wr      = i_cs & i_we;
  assign w_ctrl_wr = w_wr & (i_rs == REG_CTRL);
  assign w_stat_wr = w_wr & (i_rs == REG_STATUS);

  // START/ABORT are single-cycle strobes; the FSM decides whether they matter in its state
  assign o_start     = w_ctrl_wr & i_din[CTRL_START];
  assign o_abort     = w_ctrl_wr & i_din[CTRL_ABORT];
  assign o_irq_en    = r_irq_en;
  assign o_dst_fixed = r_dst_fixed;
  assign o_irq       = r_done & r_irq_en;
  assign o_dout      = r_dout;

  // Byte-lane write enables for SRC/DST/LEN; counters are frozen against CPU writes while busy
  always_comb begin
    o_cnt_wr = '0;
    for (int k = 0; k < 6; k++) begin
      o_cnt_wr[k] = w_wr & ~i_busy & (i_rs == 4'(k));
    end
  end

  // Read mux: counters read live, START/ABORT read back as 0, unmapped offsets read 0
  always_comb begin
    w_rd_data = 8'h00;
    case (i_rs)
      REG_SRC_LO: w_rd_data = i_src[7:0];
      REG_SRC_HI: w_rd_data = i_src[15:8];
      REG_DST_LO: w_rd_data = i_dst[7:0];
      REG_DST_HI: w_rd_data = i_dst[15:8];
      REG_LEN_LO: w_rd_data = i_len[7:0];
      REG_LEN_HI: w_rd_data = i_len[15:8];
      REG_CTRL:   w_rd_data = {5'b0, r_dst_fixed, r_irq_en, 1'b0};
      REG_STATUS: w_rd_data = {5'b0, r_aborted, r_done, i_busy};
      default:    w_rd_data = 8'h00;
    endcase
  end

  // Control bits, sticky flags (a same-cycle set beats a write-1-clear) and the registered read port
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dout      <= 8'h00;
      r_irq_en    <= 1'b0;
      r_dst_fixed <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      if (i_cs) r_dout <= w_rd_data;
      if (w_ctrl_wr) begin
        r_irq_en    <= i_din[CTRL_IRQ_EN];
        r_dst_fixed <= i_din[CTRL_DST_FIXED];
      end
      if (i_set_done)                         r_done <= 1'b1;
      else if (w_stat_wr && i_din[STAT_DONE]) r_done <= 1'b0;
      if (i_set_aborted)                         r_aborted <= 1'b1;
      else if (w_stat_wr && i_din[STAT_ABORTED]) r_aborted <= 1'b0;
    end
  end

endmodule

// File: rtl/dma_controller.sv
// rtl/dma_controller.sv - burst memory-to-memory byte DMA master with CPU-visible register slot
module dma_controller
  import dma_controller_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int BURST_LEN    = 16,
  parameter int YIELD_CYCLES = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cs,
  input  logic              i_we,
  input  logic [3:0]        i_rs,
  input  logic [7:0]        i_din,
  output logic [7:0]        o_dout,
  output logic              o_bus_req,
  input  logic              i_bus_gnt,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [7:0]        o_mem_wdata,
  input  logic [7:0]        i_mem_rdata,
  output logic              o_irq
);

  dma_state_t        r_state;
  logic [15:0]       r_src;
  logic [15:0]       r_dst;
  logic [15:0]       r_len;
  logic [15:0]       r_burst_cnt;
  logic [15:0]       r_yield_cnt;
  logic              r_abort_lat;
  logic              r_bus_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;

  logic        w_busy;
  logic [5:0]  w_cnt_wr;
  logic        w_start;
  logic        w_abort;
  logic        w_irq_en;
  logic        w_dst_fixed;
  logic [15:0] w_src_inc;
  logic [15:0] w_dst_next;
  logic [15:0] w_len_dec;
  logic [15:0] w_burst_inc;
  logic        w_abort_now;
  logic        w_set_done;
  logic        w_set_aborted;

  assign w_busy      = (r_state != ST_IDLE);
  assign w_src_inc   = r_src + 16'd1;
  assign w_dst_next  = w_dst_fixed ? r_dst : (r_dst + 16'd1);
  assign w_len_dec   = r_len - 16'd1;
  assign w_burst_inc = r_burst_cnt + 16'd1;
  // An abort written during the WR cycle itself takes effect at that byte's exit
  assign w_abort_now = r_abort_lat | w_abort;

  assign w_set_done = ((r_state == ST_IDLE) && w_start && (r_len == 16'd0)) ||
                      ((r_state == ST_WR) && (w_len_dec == 16'd0));
  assign w_set_aborted = ((r_state == ST_WR) && (w_len_dec != 16'd0) && w_abort_now) ||
                         ((r_state == ST_YIELD) && w_abort);

  assign o_bus_req  = r_bus_req;
  assign o_mem_we   = r_mem_we;
  assign o_mem_addr = r_mem_addr;
  // Read data arrives only during WR (one-cycle RAM latency), so it is forwarded straight through
  assign o_mem_wdata = r_mem_we ? i_mem_rdata : 8'h00;

  dma_controller_regs u_regs (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_cs          (i_cs),
    .i_we          (i_we),
    .i_rs          (i_rs),
    .i_din         (i_din),
    .i_busy        (w_busy),
    .i_src         (r_src),
    .i_dst         (r_dst),
    .i_len         (r_len),
    .i_set_done    (w_set_done),
    .i_set_aborted (w_set_aborted),
    .o_dout        (o_dout),
    .o_cnt_wr      (w_cnt_wr),
    .o_start       (w_start),
    .o_abort       (w_abort),
    .o_irq_en      (w_irq_en),
    .o_dst_fixed   (w_dst_fixed),
    .o_irq         (o_irq)
  );

  // Transfer FSM: owns the address/length counters and registers every bus-facing output
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_src       <= 16'h0000;
      r_dst       <= 16'h0000;
      r_len       <= 16'h0000;
      r_burst_cnt <= 16'h0000;
      r_yield_cnt <= 16'h0000;
      r_abort_lat <= 1'b0;
      r_bus_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_abort_lat <= 1'b0;
          if (w_cnt_wr[0]) r_src[7:0]  <= i_din;
          if (w_cnt_wr[1]) r_src[15:8] <= i_din;
          if (w_cnt_wr[2]) r_dst[7:0]  <= i_din;
          if (w_cnt_wr[3]) r_dst[15:8] <= i_din;
          if (w_cnt_wr[4]) r_len[7:0]  <= i_din;
          if (w_cnt_wr[5]) r_len[15:8] <= i_din;
          if (w_start && (r_len != 16'd0)) begin
            r_state     <= ST_REQ;
            r_bus_req   <= 1'b1;
            r_burst_cnt <= 16'h0000;
          end
        end
        ST_REQ: begin
          if (w_abort) r_abort_lat <= 1'b1;
          if (i_bus_gnt) begin
            r_state    <= ST_RD;
            r_mem_addr <= r_src[ADDR_W-1:0];
          end
        end
        ST_RD: begin
          if (w_abort) r_abort_lat <= 1'b1;
          r_state    <= ST_WR;
          r_mem_addr <= r_dst[ADDR_W-1:0];
          r_mem_we   <= 1'b1;
        end
        ST_WR: begin
          r_src       <= w_src_inc;
          r_dst       <= w_dst_next;
          r_len       <= w_len_dec;
          r_burst_cnt <= w_burst_inc;
          r_mem_we    <= 1'b0;
          if (w_len_dec == 16'd0) begin
            r_state   <= ST_IDLE;
            r_bus_req <= 1'b0;
          end else if (w_abort_now) begin
            r_state   <= ST_IDLE;
            r_bus_req <= 1'b0;
          end else if (w_burst_inc == 16'(BURST_LEN)) begin
            r_state     <= ST_YIELD;
            r_bus_req   <= 1'b0;
            r_yield_cnt <= 16'h0000;
          end else begin
            r_state    <= ST_RD;
            r_mem_addr <= w_src_inc[ADDR_W-1:0];
          end
        end
        ST_YIELD: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
          end else if (r_yield_cnt == 16'(YIELD_CYCLES - 1)) begin
            r_state     <= ST_REQ;
            r_bus_req   <= 1'b1;
            r_burst_cnt <= 16'h0000;
          end else begin
            r_yield_cnt <= r_yield_cnt + 16'd1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_bus_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule
